regs_wb_ctrl: RTL and testbench

//  Write-back port controller for the 32x32 register file. Shares the file's single write port between
//  EX (single-cycle, priority) and LSU (multi-cycle loads, valid/ready). Keeps a pending-write scoreboard

---
 rtl/regs_wb_ctrl_pkg.sv | 20 ++
 rtl/regs_wb_ctrl_if.sv | 30 +++
 rtl/regs_wb_ctrl_sb.sv | 29 ++
 rtl/regs_wb_ctrl.sv | 46 ++++
 tb/tb_regs_wb_ctrl.sv | 110 +++++++++++
 5 files changed

// File: rtl/regs_wb_ctrl_pkg.sv
// regs_wb_ctrl_pkg: shared widths, types and hazard helper for the write-back controller
package regs_wb_ctrl_pkg;
  localparam int REGS_NUM = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REGS_NUM-1:0] pend_t;
  typedef struct packed {
    logic valid;
    reg_addr_t addr;
    word_t data;
  } wb_t;
  // A register draining this cycle is not a hazard: the regfile bypasses its write data to reads
  function automatic logic hz(pend_t p, reg_addr_t a, logic drain, reg_addr_t da);
    return p[a] && a != '0 && !(drain && da == a);
  endfunction
endpackage

// File: rtl/regs_wb_ctrl_if.sv
// regs_wb_ctrl_if: EX/LSU/ID/regfile signals around the write-back controller
interface regs_wb_ctrl_if;
  import regs_wb_ctrl_pkg::*;
  logic ex_wb_valid;
  reg_addr_t ex_wb_addr;
  word_t ex_wb_data;
  logic ex_stall;
  logic lsu_wb_valid;
  logic lsu_wb_ready;
  reg_addr_t lsu_wb_addr;
  word_t lsu_wb_data;
  logic id_issue;
  logic id_issue_long;
  reg_addr_t id_rd_addr;
  reg_addr_t id_rs1_addr;
  reg_addr_t id_rs2_addr;
  logic id_stall;
  reg_addr_t regs_rd_addr;
  word_t regs_rd_data;
  modport master(
    output ex_wb_valid, ex_wb_addr, ex_wb_data, lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
           id_issue, id_issue_long, id_rd_addr, id_rs1_addr, id_rs2_addr,
    input  ex_stall, lsu_wb_ready, id_stall, regs_rd_addr, regs_rd_data
  );
  modport slave(
    input  ex_wb_valid, ex_wb_addr, ex_wb_data, lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
           id_issue, id_issue_long, id_rd_addr, id_rs1_addr, id_rs2_addr,
    output ex_stall, lsu_wb_ready, id_stall, regs_rd_addr, regs_rd_data
  );
endinterface

// File: rtl/regs_wb_ctrl_sb.sv
// regs_wb_ctrl_sb: pending-load scoreboard raising the ID stall on RAW/WAW hazards
module regs_wb_ctrl_sb
  import regs_wb_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rest,
  input  logic      issue_long,
  input  reg_addr_t rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  logic      drain,
  input  reg_addr_t drain_addr,
  output logic      id_stall
);
  pend_t pending;
  logic set;
  always_comb begin
    id_stall = rest & (hz(pending, rs1, drain, drain_addr) | hz(pending, rs2, drain, drain_addr)
             | hz(pending, rd, drain, drain_addr));
    set = issue_long & ~id_stall & (rd != '0);
  end
  // The set is written last so a same-cycle set and clear of one register leaves it pending
  always_ff @(posedge clk)
    if (!rest) pending <= '0;
    else begin
      if (drain) pending[drain_addr] <= 1'b0;
      if (set) pending[rd] <= 1'b1;
    end
endmodule

// File: rtl/regs_wb_ctrl.sv
// regs_wb_ctrl: shares the regfile write port between EX and a buffered LSU result
module regs_wb_ctrl
  import regs_wb_ctrl_pkg::*;
(
  input logic          clk,
  input logic          rest,
  regs_wb_ctrl_if.slave bus
);
  wb_t buf_q;
  logic [CNT_W-1:0] starve_cnt;
  logic drain, contend, accept, id_stall;
  always_comb begin
    drain = buf_q.valid & ~bus.ex_wb_valid;
    contend = buf_q.valid & bus.ex_wb_valid;
    bus.lsu_wb_ready = rest & ~buf_q.valid;
    accept = bus.lsu_wb_valid & bus.lsu_wb_ready;
    bus.regs_rd_addr = !rest ? '0 : bus.ex_wb_valid ? bus.ex_wb_addr : buf_q.valid ? buf_q.addr : '0;
    bus.regs_rd_data = (!rest || bus.regs_rd_addr == '0) ? '0 : bus.ex_wb_valid ? bus.ex_wb_data : buf_q.data;
    bus.id_stall = id_stall;
  end
  // One-cycle EX bubble after the held load has lost STARVE_MAX arbitrations in a row
  always_ff @(posedge clk)
    if (!rest) begin
      buf_q <= '0;
      starve_cnt <= '0;
      bus.ex_stall <= 1'b0;
    end else begin
      if (accept) buf_q <= '{1'b1, bus.lsu_wb_addr, bus.lsu_wb_data};
      else if (drain) buf_q.valid <= 1'b0;
      starve_cnt <= drain ? '0 : contend ? starve_cnt + 1'b1 : starve_cnt;
      bus.ex_stall <= contend && starve_cnt == CNT_W'(STARVE_MAX - 1);
    end
  regs_wb_ctrl_sb u_sb (
    .clk        (clk),
    .rest       (rest),
    .issue_long (bus.id_issue & bus.id_issue_long),
    .rd         (bus.id_rd_addr),
    .rs1        (bus.id_rs1_addr),
    .rs2        (bus.id_rs2_addr),
    .drain      (drain),
    .drain_addr (buf_q.addr),
    .id_stall   (id_stall)
  );
  a_no_ex_in_bubble: assert property (@(posedge clk) disable iff (!rest) !(bus.ex_stall && bus.ex_wb_valid))
    else $error("EX result presented during ex_stall bubble");
endmodule

// File: tb/tb_regs_wb_ctrl.sv
// tb_regs_wb_ctrl: cycle-by-cycle vector table with an expected-result queue for regs_wb_ctrl
module tb_regs_wb_ctrl;
  import regs_wb_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rest = 1'b0;
  always #5 clk = ~clk;
  regs_wb_ctrl_if bus();
  regs_wb_ctrl dut (.clk(clk), .rest(rest), .bus(bus));
  typedef struct {
    logic rn, exv; reg_addr_t exa; word_t exd;
    logic lv; reg_addr_t la; word_t ld;
    logic iss, lng; reg_addr_t rd, rs1, rs2;
    logic rdy, ids, exs; reg_addr_t ra; word_t rdat;
  } vec_t;
  typedef struct {
    int id; logic rdy, ids, exs; reg_addr_t ra; word_t rdat;
  } exp_t;
  vec_t tbl[$];
  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  task automatic chk(string nm, int id, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL vec%0d %s: got %h want %h", id, nm, act, req);
    end
  endtask
  task automatic apply(int id, vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rest = v.rn;
    bus.ex_wb_valid = v.exv; bus.ex_wb_addr = v.exa; bus.ex_wb_data = v.exd;
    bus.lsu_wb_valid = v.lv; bus.lsu_wb_addr = v.la; bus.lsu_wb_data = v.ld;
    bus.id_issue = v.iss; bus.id_issue_long = v.lng;
    bus.id_rd_addr = v.rd; bus.id_rs1_addr = v.rs1; bus.id_rs2_addr = v.rs2;
    sbq.push_back('{id, v.rdy, v.ids, v.exs, v.ra, v.rdat});
    @(negedge clk);
    e = sbq.pop_front();
    chk("lsu_wb_ready", e.id, 32'(bus.lsu_wb_ready), 32'(e.rdy));
    chk("id_stall", e.id, 32'(bus.id_stall), 32'(e.ids));
    chk("ex_stall", e.id, 32'(bus.ex_stall), 32'(e.exs));
    chk("regs_rd_addr", e.id, 32'(bus.regs_rd_addr), 32'(e.ra));
    chk("regs_rd_data", e.id, bus.regs_rd_data, e.rdat);
  endtask
  function automatic vec_t idle();
    vec_t v = '{default: 0};
    v.rn = 1'b1;
    v.rdy = 1'b1;
    return v;
  endfunction
  initial begin
    vec_t v;
    // rn exv exa exd | lv la ld | iss lng rd rs1 rs2 || rdy ids exs ra rdat
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0,   0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 5, 'h1234,   0, 0, 0,        0, 0, 0, 0, 0,   1, 0, 0, 5, 'h1234});
    tbl.push_back('{1, 1, 0, 'hFFFF,   0, 0, 0,        0, 0, 0, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        1, 1, 0, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        1, 7, 'hCAFE,   0, 0, 0, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        1, 8, 'hBEEF,   0, 0, 0, 0, 0,   0, 0, 0, 7, 'hCAFE});
    tbl.push_back('{1, 0, 0, 0,        1, 8, 'hBEEF,   0, 0, 0, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0,   0, 0, 0, 8, 'hBEEF});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        1, 1, 9, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 9, 0,   1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        1, 9, 'h99,     0, 0, 0, 9, 0,   1, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 4, 'h44,     0, 0, 0,        0, 0, 0, 9, 0,   0, 1, 0, 4, 'h44});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 9, 0,   0, 0, 0, 9, 'h99});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 9,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        1, 10, 'hA,     0, 0, 0, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 'h11,     0, 0, 0,        0, 0, 0, 0, 0,   0, 0, 0, 1, 'h11});
    tbl.push_back('{1, 1, 2, 'h22,     0, 0, 0,        0, 0, 0, 0, 0,   0, 0, 0, 2, 'h22});
    tbl.push_back('{1, 1, 3, 'h33,     0, 0, 0,        0, 0, 0, 0, 0,   0, 0, 0, 3, 'h33});
    tbl.push_back('{1, 1, 4, 'h44,     0, 0, 0,        0, 0, 0, 0, 0,   0, 0, 0, 4, 'h44});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0,   0, 0, 1, 10, 'hA});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        1, 11, 'hB,     1, 1, 3, 0, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 6, 'h66,     0, 0, 0,        0, 0, 0, 3, 0,   0, 1, 0, 6, 'h66});
    tbl.push_back('{0, 1, 6, 'h66,     0, 0, 0,        0, 0, 0, 3, 0,   0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 3, 0,   1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        1, 12, 'hC,     1, 1, 12, 0, 0,  1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        1, 1, 12, 0, 0,  0, 0, 0, 12, 'hC});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 12, 0,  1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        1, 12, 'hD,     0, 0, 0, 12, 0,  1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 12, 0,  0, 0, 0, 12, 'hD});
    tbl.push_back('{1, 0, 0, 0,        0, 0, 0,        0, 0, 0, 12, 0,  1, 0, 0, 0, 0});
    bus.ex_wb_valid = 1'b0; bus.ex_wb_addr = '0; bus.ex_wb_data = '0;
    bus.lsu_wb_valid = 1'b0; bus.lsu_wb_addr = '0; bus.lsu_wb_data = '0;
    bus.id_issue = 1'b0; bus.id_issue_long = 1'b0;
    bus.id_rd_addr = '0; bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
    repeat (2) @(posedge clk);
    foreach (tbl[i]) apply(i, tbl[i]);
    // Second contention burst: the bubble must again land after exactly four lost cycles
    v = idle(); v.lv = 1'b1; v.la = 5'd13; v.ld = 32'hE;
    apply(100, v);
    for (int k = 0; k < STARVE_MAX; k++) begin
      v = idle(); v.rdy = 1'b0; v.exv = 1'b1; v.exa = 5'd1; v.exd = 32'h100 + 32'(k);
      v.ra = 5'd1; v.rdat = 32'h100 + 32'(k);
      apply(101 + k, v);
    end
    v = idle(); v.rdy = 1'b0; v.exs = 1'b1; v.ra = 5'd13; v.rdat = 32'hE;
    apply(105, v);
    v = idle();
    apply(106, v);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
